// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Finite-state controller for a multi-cycle RV32I datapath that shares a
// single instruction/data memory port. Each instruction is stepped through
// fetch, decode, execute, memory and write-back. The controller drives every
// datapath mux select and register write enable, and it waits on a memory
// ready handshake.
//
// Configuration macro:
//   MC_CTRL_JUMP_EN  defined   : JAL / JALR are sequenced (states 10..12).
//                    undefined : opcodes 1101111 / 1100111 halt as illegal.
//
// Ports:
//   i_clk         clock; every state change happens on the rising edge
//   i_reset       synchronous, active-high reset
//   i_opcode      IR[6:0]; valid from DECODE onward
//   i_alu_zero    ALU zero flag (combinational from the datapath)
//   i_mem_ready   memory completes the current read/write this cycle
//   o_mem_read    memory read request
//   o_mem_write   memory write request
//   o_i_or_d      memory address select: 0 = PC, 1 = ALU-result register
//   o_ir_write    load IR (and old-PC) from memory data
//   o_pc_write    load PC
//   o_pc_src      PC source: 0 = live ALU output, 1 = ALU-result register
//   o_alu_src_a   A select: 00 = PC, 01 = rs1, 10 = old-PC
//   o_alu_src_b   B select: 00 = rs2, 01 = constant 4, 10 = immediate
//   o_alu_op      00 = add, 01 = sub/compare, 10 = R-type funct, 11 = I-type
//   o_reg_write   register file write enable
//   o_wb_sel      write data: 00 = ALU-result reg, 01 = mem data, 10 = PC
//   o_instr_done  one-cycle pulse on the last cycle of each instruction
//   o_illegal     sticky: unsupported opcode decoded
//   o_state       current state encoding, for debug
//
// The state and the sticky illegal flag are the only flops. All control
// outputs are decoded from the registered state, so they are glitch-free
// with respect to state changes; the few that must react to the handshake
// in the same cycle (ir_write, pc_write on fetch, branch pc_write, and the
// completion of memory phases) also look at i_mem_ready / i_alu_zero, and
// all outputs are forced low while i_reset is high so no write enable can
// fire in a reset cycle.
// -----------------------------------------------------------------------------
module multicycle_control (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [6:0] i_opcode,
  input  logic       i_alu_zero,
  input  logic       i_mem_ready,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_i_or_d,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic       o_pc_src,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic       o_reg_write,
  output logic [1:0] o_wb_sel,
  output logic       o_instr_done,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
`ifdef MC_CTRL_JUMP_EN
    S_JAL       = 4'd10,
    S_JALR_ADDR = 4'd11,
    S_JALR_WB   = 4'd12,
`endif
    S_HALT      = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_RS1   = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC = 2'b10;
  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;
  localparam logic [1:0] ALU_ADD     = 2'b00;
  localparam logic [1:0] ALU_SUB     = 2'b01;
  localparam logic [1:0] ALU_RFUNCT  = 2'b10;
  localparam logic [1:0] ALU_IFUNCT  = 2'b11;
  localparam logic [1:0] WB_ALUOUT   = 2'b00;
  localparam logic [1:0] WB_MEM      = 2'b01;
  localparam logic [1:0] WB_PC       = 2'b10;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  // Next-state and control-output decode from the registered state.
  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_i_or_d     = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_pc_src     = 1'b0;
    o_alu_src_a  = SRC_A_PC;
    o_alu_src_b  = SRC_B_RS2;
    o_alu_op     = ALU_ADD;
    o_reg_write  = 1'b0;
    o_wb_sel     = WB_ALUOUT;
    o_instr_done = 1'b0;
    o_illegal    = 1'b0;
    o_state      = 4'd0;

    if (i_reset) begin
      // Everything stays at its quiet default; the flop block loads FETCH.
      state_d   = S_FETCH;
      illegal_d = 1'b0;
    end else begin
      o_state   = state_q;
      o_illegal = illegal_q;

      case (state_q)
        S_FETCH: begin
          // ALU computes PC+4 while the instruction word is read.
          o_mem_read  = 1'b1;
          o_alu_src_b = SRC_B_FOUR;
          if (i_mem_ready) begin
            o_ir_write = 1'b1;
            o_pc_write = 1'b1;
            state_d    = S_DECODE;
          end else begin
            state_d    = S_FETCH;
          end
        end

        S_DECODE: begin
          // old-PC + imm is latched speculatively as the branch/jump target.
          o_alu_src_a = SRC_A_OLDPC;
          o_alu_src_b = SRC_B_IMM;
          case (i_opcode)
            OP_LOAD,
            OP_STORE:  state_d = S_MEM_ADDR;
            OP_RTYPE:  state_d = S_EXEC_R;
            OP_ITYPE:  state_d = S_EXEC_I;
            OP_BRANCH: state_d = S_BRANCH;
`ifdef MC_CTRL_JUMP_EN
            OP_JAL:    state_d = S_JAL;
            OP_JALR:   state_d = S_JALR_ADDR;
`else
            OP_JAL,
            OP_JALR: begin
              state_d   = S_HALT;
              illegal_d = 1'b1;
            end
`endif
            default: begin
              state_d   = S_HALT;
              illegal_d = 1'b1;
            end
          endcase
        end

        S_MEM_ADDR: begin
          o_alu_src_a = SRC_A_RS1;
          o_alu_src_b = SRC_B_IMM;
          if (i_opcode == OP_LOAD) begin
            state_d = S_MEM_READ;
          end else begin
            state_d = S_MEM_WRITE;
          end
        end

        S_MEM_READ: begin
          o_mem_read = 1'b1;
          o_i_or_d   = 1'b1;
          if (i_mem_ready) begin
            state_d = S_MEM_WB;
          end else begin
            state_d = S_MEM_READ;
          end
        end

        S_MEM_WB: begin
          o_reg_write  = 1'b1;
          o_wb_sel     = WB_MEM;
          o_instr_done = 1'b1;
          state_d      = S_FETCH;
        end

        S_MEM_WRITE: begin
          // A store finishes in the cycle the memory accepts the write.
          o_mem_write = 1'b1;
          o_i_or_d    = 1'b1;
          if (i_mem_ready) begin
            o_instr_done = 1'b1;
            state_d      = S_FETCH;
          end else begin
            state_d      = S_MEM_WRITE;
          end
        end

        S_EXEC_R: begin
          o_alu_src_a = SRC_A_RS1;
          o_alu_src_b = SRC_B_RS2;
          o_alu_op    = ALU_RFUNCT;
          state_d     = S_ALU_WB;
        end

        S_EXEC_I: begin
          o_alu_src_a = SRC_A_RS1;
          o_alu_src_b = SRC_B_IMM;
          o_alu_op    = ALU_IFUNCT;
          state_d     = S_ALU_WB;
        end

        S_ALU_WB: begin
          o_reg_write  = 1'b1;
          o_wb_sel     = WB_ALUOUT;
          o_instr_done = 1'b1;
          state_d      = S_FETCH;
        end

        S_BRANCH: begin
          // Compare rs1-rs2; the target latched in DECODE is taken on zero.
          o_alu_src_a  = SRC_A_RS1;
          o_alu_src_b  = SRC_B_RS2;
          o_alu_op     = ALU_SUB;
          o_pc_src     = 1'b1;
          o_pc_write   = i_alu_zero;
          o_instr_done = 1'b1;
          state_d      = S_FETCH;
        end

`ifdef MC_CTRL_JUMP_EN
        S_JAL: begin
          // PC already holds old-PC+4, which becomes the link value.
          o_reg_write  = 1'b1;
          o_wb_sel     = WB_PC;
          o_pc_write   = 1'b1;
          o_pc_src     = 1'b1;
          o_instr_done = 1'b1;
          state_d      = S_FETCH;
        end

        S_JALR_ADDR: begin
          o_alu_src_a = SRC_A_RS1;
          o_alu_src_b = SRC_B_IMM;
          o_alu_op    = ALU_ADD;
          state_d     = S_JALR_WB;
        end

        S_JALR_WB: begin
          // Datapath clears bit 0 of the rs1+imm target on the PC load.
          o_reg_write  = 1'b1;
          o_wb_sel     = WB_PC;
          o_pc_write   = 1'b1;
          o_pc_src     = 1'b1;
          o_instr_done = 1'b1;
          state_d      = S_FETCH;
        end
`endif

        S_HALT: begin
          // Terminal until reset; only the illegal flag is visible.
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end

        default: begin
          // Unused encodings are treated as a fault and parked in HALT.
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      endcase
    end
  end

  // State and sticky illegal flag registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed and randomized checks of multicycle_control against a reference
// model that predicts, per instruction, the sequence of states visited and
// the number of cycles each control strobe is active.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  logic       i_clk;
  logic       i_reset;
  logic [6:0] i_opcode;
  logic       i_alu_zero;
  logic       i_mem_ready;
  logic       o_mem_read;
  logic       o_mem_write;
  logic       o_i_or_d;
  logic       o_ir_write;
  logic       o_pc_write;
  logic       o_pc_src;
  logic [1:0] o_alu_src_a;
  logic [1:0] o_alu_src_b;
  logic [1:0] o_alu_op;
  logic       o_reg_write;
  logic [1:0] o_wb_sel;
  logic       o_instr_done;
  logic       o_illegal;
  logic [3:0] o_state;

  int n_assert = 0;
  int n_fail   = 0;

  multicycle_control dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_opcode     (i_opcode),
    .i_alu_zero   (i_alu_zero),
    .i_mem_ready  (i_mem_ready),
    .o_mem_read   (o_mem_read),
    .o_mem_write  (o_mem_write),
    .o_i_or_d     (o_i_or_d),
    .o_ir_write   (o_ir_write),
    .o_pc_write   (o_pc_write),
    .o_pc_src     (o_pc_src),
    .o_alu_src_a  (o_alu_src_a),
    .o_alu_src_b  (o_alu_src_b),
    .o_alu_op     (o_alu_op),
    .o_reg_write  (o_reg_write),
    .o_wb_sel     (o_wb_sel),
    .o_instr_done (o_instr_done),
    .o_illegal    (o_illegal),
    .o_state      (o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Instruction classes used by the reference model.
  localparam int C_LOAD = 0, C_STORE = 1, C_R = 2, C_I = 3, C_BR = 4,
                 C_JAL = 5, C_JALR = 6, C_ILL = 7;

`ifdef MC_CTRL_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] all_outs();
    return {o_mem_read, o_mem_write, o_i_or_d, o_ir_write, o_pc_write, o_pc_src,
            o_alu_src_a, o_alu_src_b, o_alu_op, o_reg_write, o_wb_sel,
            o_instr_done, o_illegal, o_state};
  endfunction

  function automatic int classify(input logic [6:0] op);
    case (op)
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b1100011: return C_BR;
      7'b1101111: return JUMP_EN ? C_JAL : C_ILL;
      7'b1100111: return JUMP_EN ? C_JALR : C_ILL;
      default:    return C_ILL;
    endcase
  endfunction

  // Run one legal instruction: fw wait cycles on fetch, mw on the data access.
  task automatic run_instr(input string name, input logic [6:0] op, input int fw,
                           input int mw, input logic zero);
    int q[$];
    int cl, f, m, last;
    int rd_cnt, wr_cnt, iod_cnt, pcw_cnt, irw_cnt, rw_cnt, done_cnt;
    bit regwb;
    logic [1:0] exp_wb;
    cl = classify(op);
    // Expected state trace from the instruction's step list.
    for (int k = 0; k <= fw; k++) q.push_back(0);
    q.push_back(1);
    case (cl)
      C_LOAD:  begin q.push_back(2); for (int k = 0; k <= mw; k++) q.push_back(3); q.push_back(4); end
      C_STORE: begin q.push_back(2); for (int k = 0; k <= mw; k++) q.push_back(5); end
      C_R:     begin q.push_back(6); q.push_back(8); end
      C_I:     begin q.push_back(7); q.push_back(8); end
      C_BR:    q.push_back(9);
      C_JAL:   q.push_back(10);
      C_JALR:  begin q.push_back(11); q.push_back(12); end
      default: q.push_back(15);
    endcase
    last   = q.size() - 1;
    regwb  = (cl == C_LOAD) || (cl == C_R) || (cl == C_I) || (cl == C_JAL) || (cl == C_JALR);
    exp_wb = (cl == C_LOAD) ? 2'b01 : ((cl == C_JAL || cl == C_JALR) ? 2'b10 : 2'b00);
    f = fw; m = mw;
    rd_cnt = 0; wr_cnt = 0; iod_cnt = 0; pcw_cnt = 0; irw_cnt = 0; rw_cnt = 0; done_cnt = 0;
    i_opcode   = op;
    i_alu_zero = zero;
    for (int c = 0; c <= last; c++) begin
      @(negedge i_clk);
      // Memory model: stall for the requested number of cycles per access.
      if ((o_mem_read || o_mem_write) && !o_i_or_d) begin
        if (f > 0) begin i_mem_ready = 1'b0; f--; end else i_mem_ready = 1'b1;
      end else if (o_mem_read || o_mem_write) begin
        if (m > 0) begin i_mem_ready = 1'b0; m--; end else i_mem_ready = 1'b1;
      end else begin
        i_mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      chk({name, " state"}, 32'(o_state), 32'(q[c]));
      chk({name, " done"}, 32'(o_instr_done), 32'(c == last));
      chk({name, " illegal"}, 32'(o_illegal), 32'd0);
      if (c == fw + 1) begin
        chk({name, " decode srcs"}, {28'd0, o_alu_src_a, o_alu_src_b}, 32'b1010);
      end
      if (o_ir_write) begin
        chk({name, " ir_write cycle"}, 32'(c), 32'(fw));
        chk({name, " fetch pc_src/src_b/op"}, {27'd0, o_pc_src, o_alu_src_b, o_alu_op}, 32'b00100);
      end
      if (o_reg_write) chk({name, " wb_sel"}, 32'(o_wb_sel), 32'(exp_wb));
      if (o_pc_write && c > fw) chk({name, " pc_src late"}, 32'(o_pc_src), 32'd1);
      if ((cl == C_JAL || cl == C_JALR) && c == last)
        chk({name, " jump wb+pc"}, {30'd0, o_reg_write, o_pc_write}, 32'b11);
      rd_cnt   += int'(o_mem_read);
      wr_cnt   += int'(o_mem_write);
      iod_cnt  += int'(o_i_or_d);
      pcw_cnt  += int'(o_pc_write);
      irw_cnt  += int'(o_ir_write);
      rw_cnt   += int'(o_reg_write);
      done_cnt += int'(o_instr_done);
    end
    chk({name, " mem_read cycles"}, 32'(rd_cnt), 32'((fw + 1) + ((cl == C_LOAD) ? mw + 1 : 0)));
    chk({name, " mem_write cycles"}, 32'(wr_cnt), 32'((cl == C_STORE) ? mw + 1 : 0));
    chk({name, " i_or_d cycles"}, 32'(iod_cnt), 32'((cl == C_LOAD || cl == C_STORE) ? mw + 1 : 0));
    chk({name, " pc_write cycles"}, 32'(pcw_cnt),
        32'(1 + (((cl == C_BR) && zero) || cl == C_JAL || cl == C_JALR ? 1 : 0)));
    chk({name, " ir_write cycles"}, 32'(irw_cnt), 32'd1);
    chk({name, " reg_write cycles"}, 32'(rw_cnt), 32'(regwb ? 1 : 0));
    chk({name, " done pulses"}, 32'(done_cnt), 32'd1);
  endtask

  // Apply reset at a negedge for one cycle, then release and check FETCH.
  task automatic pulse_reset(input string name);
    @(negedge i_clk);
    i_reset     = 1'b1;
    i_mem_ready = 1'b0;
    #1;
    chk({name, " outputs in reset"}, 32'(all_outs()), 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    chk({name, " state after reset"}, 32'(o_state), 32'd0);
    chk({name, " illegal after reset"}, 32'(o_illegal), 32'd0);
    chk({name, " first fetch"}, {30'd0, o_mem_read, o_i_or_d}, 32'b10);
    @(posedge i_clk);
  endtask

  // Drive an unsupported opcode and confirm HALT is held.
  task automatic halt_check(input string name, input logic [6:0] op);
    i_opcode = op;
    @(negedge i_clk); i_mem_ready = 1'b1; #1;
    chk({name, " fetch"}, 32'(o_state), 32'd0);
    @(negedge i_clk); #1;
    chk({name, " decode"}, 32'(o_state), 32'd1);
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      i_mem_ready = 1'($urandom_range(0, 1));
      #1;
      chk({name, " halt state/illegal"}, {27'd0, o_illegal, o_state}, 32'h1F);
      chk({name, " halt quiet"}, 32'(all_outs() & 21'h1FFFE0), 32'd0);
    end
    pulse_reset({name, " reset"});
  endtask

  logic [6:0] legal_ops[$];

  initial begin
    i_reset     = 1'b1;
    i_opcode    = 7'd0;
    i_alu_zero  = 1'b0;
    i_mem_ready = 1'b0;
    // Power-on reset: outputs quiet while reset is high.
    @(negedge i_clk); #1;
    @(negedge i_clk); #1;
    chk("por outputs", 32'(all_outs()), 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    chk("por state", 32'(o_state), 32'd0);
    chk("por first fetch", 32'(o_mem_read), 32'd1);
    @(posedge i_clk);

    // Directed scenarios.
    run_instr("rtype", 7'b0110011, 0, 0, 1'b0);
    run_instr("rtype2", 7'b0110011, 0, 0, 1'b1);
    run_instr("load_w2", 7'b0000011, 0, 2, 1'b0);
    run_instr("br_taken", 7'b1100011, 0, 0, 1'b1);
    run_instr("br_not", 7'b1100011, 0, 0, 1'b0);
    run_instr("store_w1", 7'b0100011, 0, 1, 1'b0);
    run_instr("itype_fw3", 7'b0010011, 3, 0, 1'b0);

    halt_check("ill_7f", 7'b1111111);

`ifdef MC_CTRL_JUMP_EN
    run_instr("jal", 7'b1101111, 0, 0, 1'b0);
    run_instr("jalr", 7'b1100111, 1, 0, 1'b0);
`else
    halt_check("jal_off", 7'b1101111);
    halt_check("jalr_off", 7'b1100111);
`endif

    // Reset while a store is waiting in MEM_WRITE.
    i_opcode = 7'b0100011;
    @(negedge i_clk); i_mem_ready = 1'b1; #1;
    @(negedge i_clk); i_mem_ready = 1'b0; #1;
    @(negedge i_clk); #1;
    @(negedge i_clk); #1;
    chk("rst_store in write", {27'd0, o_mem_write, o_state}, 32'h15);
    @(negedge i_clk); #1;
    chk("rst_store still waiting", 32'(o_state), 32'd5);
    pulse_reset("rst_store");

    // Randomized instruction stream with random wait states.
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011};
    if (JUMP_EN) begin
      legal_ops.push_back(7'b1101111);
      legal_ops.push_back(7'b1100111);
    end
    for (int n = 0; n < 40; n++) begin
      run_instr("rand", legal_ops[$urandom_range(0, legal_ops.size() - 1)],
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
